// File: rtl/riscv_pkg.sv
// Shared core types: bus encodings and OBI responder constants.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } rdwr;

  typedef enum logic {
    NOREQUEST = 1'b0,
    REQUEST   = 1'b1
  } obi_req;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_WAIT,
    RSP_RESP
  } t_obi_rsp_state;

  localparam int unsigned obi_max_latency = 15;

endpackage

// File: rtl/obi_mem_responder_if.sv
// OBI data-side bus between the MEM-stage initiator and the memory responder.
// OBI_MEM_ERR_EN adds the out-of-range err response signal.
interface obi_mem_responder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             proc_req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             mem_rdy;
  logic             valid;
  logic [WIDTH-1:0] rdata;
`ifdef OBI_MEM_ERR_EN
  logic             err;

  modport master (
    output proc_req, we, addr, wdata,
    input  mem_rdy, valid, rdata, err
  );

  modport slave (
    input  proc_req, we, addr, wdata,
    output mem_rdy, valid, rdata, err
  );
`else
  modport master (
    output proc_req, we, addr, wdata,
    input  mem_rdy, valid, rdata
  );

  modport slave (
    input  proc_req, we, addr, wdata,
    output mem_rdy, valid, rdata
  );
`endif
endinterface

// File: rtl/obi_sram_sp.sv
// Single-port synchronous RAM with registered read; array is never reset.
module obi_sram_sp #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/obi_mem_responder.sv
// OBI data memory responder: one request at a time, LATENCY wait cycles, one-cycle response.
// Define OBI_MEM_ERR_EN to flag out-of-range accesses on err instead of wrapping.
module obi_mem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH   = XLEN,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 1
) (
  input logic                  clk,
  input logic                  rst,
  obi_mem_responder_if.slave   bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  t_obi_rsp_state   state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  rdwr              we_q, we_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             oor_q, oor_d;
  logic             oor_in;
  logic             resp;
  logic             ram_we;
  logic [IdxW-1:0]  ram_addr;
  logic [WIDTH-1:0] ram_rdata;

`ifdef OBI_MEM_ERR_EN
  assign oor_in = |bus.addr[WIDTH-1:IdxW+2];
  logic unused_addr;
  assign unused_addr = ^bus.addr[1:0];
`else
  assign oor_in = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{bus.addr[WIDTH-1:IdxW+2], bus.addr[1:0]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    oor_d   = oor_q;
    unique case (state_q)
      RSP_IDLE: begin
        if (bus.proc_req == REQUEST) begin
          we_d    = rdwr'(bus.we);
          idx_d   = bus.addr[IdxW+1:2];
          wdata_d = bus.wdata;
          oor_d   = oor_in;
          if (LATENCY > 0) begin
            state_d = RSP_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end else begin
            state_d = RSP_RESP;
          end
        end
      end
      RSP_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RSP_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RSP_RESP: state_d = RSP_IDLE;
      default:  state_d = RSP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RSP_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= READ;
      idx_q   <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      oor_q   <= oor_d;
    end
  end

  // Reset during the response cycle aborts it: no pulse and no write commit.
  assign resp     = (state_q == RSP_RESP) && !rst;
  assign ram_we   = resp && (we_q == WRITE) && !oor_q;
  // In idle the read is issued straight from the bus so LATENCY=0 still has a registered read.
  assign ram_addr = (state_q == RSP_IDLE) ? bus.addr[IdxW+1:2] : idx_q;

  assign bus.mem_rdy = (state_q == RSP_IDLE);
  assign bus.valid   = resp;
  assign bus.rdata   = (resp && (we_q == READ) && !oor_q) ? ram_rdata : '0;
`ifdef OBI_MEM_ERR_EN
  assign bus.err     = resp && oor_q;
`endif

  obi_sram_sp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_sram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_obi_mem_responder.sv
// Scoreboard bench: four responders with LATENCY 0..3 share stimulus, one selected at a time.
module tb_obi_mem_responder;
  import riscv_pkg::*;

`ifdef OBI_MEM_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        proc_req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  int          sel = 0;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]  valid_v, rdy_v, err_v;
  logic [31:0] rdata_v [4];
  logic        valid_m, rdy_m, err_m;
  logic [31:0] rdata_m;

  obi_mem_responder_if #(.WIDTH(32)) bus [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign bus[g].proc_req = proc_req && (sel == g);
    assign bus[g].we       = we;
    assign bus[g].addr     = addr;
    assign bus[g].wdata    = wdata;
    obi_mem_responder #(.WIDTH(32), .DEPTH(256), .LATENCY(g)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[g])
    );
    assign valid_v[g] = bus[g].valid;
    assign rdy_v[g]   = bus[g].mem_rdy;
    assign rdata_v[g] = bus[g].rdata;
`ifdef OBI_MEM_ERR_EN
    assign err_v[g]   = bus[g].err;
`else
    assign err_v[g]   = 1'b0;
`endif
  end

  assign valid_m = valid_v[sel];
  assign rdy_m   = rdy_v[sel];
  assign rdata_m = rdata_v[sel];
  assign err_m   = err_v[sel];

  typedef struct {
    logic [31:0] data;
    bit          err;
    int unsigned cyc;
  } exp_t;
  exp_t sbq[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (dut L=%0d, cyc %0d): got %h, expected %h", name, sel, cyc, act, exp);
    end
  endfunction

  // Monitor: every response pulse must match the head of the scoreboard, in the expected cycle.
  always @(negedge clk) begin
    exp_t e;
    check("stray valid", 32'(valid_v & ~(4'b1 << sel)), 32'd0);
    if (valid_m) begin
      if (sbq.size() == 0) begin
        check("spurious valid", 32'(valid_m), 32'd0);
      end else begin
        e = sbq.pop_front();
        check("rdata", rdata_m, e.data);
        check("valid cycle", cyc, e.cyc);
        if (ErrEn) check("err", 32'(err_m), 32'(e.err));
      end
    end else if (sbq.size() != 0 && cyc > sbq[0].cyc) begin
      e = sbq.pop_front();
      check("missing valid", 32'(valid_m), 32'd1);
    end
  end

  task automatic wait_rdy();
    int n = 0;
    @(negedge clk);
    while (!rdy_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_m) check("mem_rdy timeout", 32'(rdy_m), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard drain", sbq.size(), 32'd0);
  endtask

  // One access on DUT s (LATENCY = s). Untracked accesses return right after acceptance.
  task automatic access(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input bit e_err, input bit track, input bit churn);
    exp_t e;
    sel = s;
    wait_rdy();
    we = w;
    addr = a;
    wdata = d;
    proc_req = 1'b1;
    @(posedge clk);
    #1;
    proc_req = 1'b0;
    if (churn) begin
      addr = 32'h20;
      wdata = 32'h0;
    end
    if (track) begin
      e.data = exp;
      e.err  = e_err;
      e.cyc  = cyc + s;
      sbq.push_back(e);
      for (int k = 0; k <= s; k++) begin
        @(negedge clk);
        check("mem_rdy busy", 32'(rdy_m), 32'd0);
      end
      @(negedge clk);
      check("mem_rdy back", 32'(rdy_m), 32'd1);
      drain();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int n;
    logic [31:0] vals [4];
    vals[0] = 32'h0BAD_F00D; vals[1] = 32'h2222_2222; vals[2] = 32'h3333_3333; vals[3] = 32'hC0DE_0004;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      check("reset mem_rdy", 32'(rdy_m), 32'd1);
      check("reset valid", 32'(valid_m), 32'd0);
      check("reset rdata", rdata_m, 32'd0);
    end

    // LATENCY=1 write then read back.
    access(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 1'b0);
    access(1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);

    // LATENCY=0 preload then read.
    access(0, 1'b1, 32'h0, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 1'b0);
    access(0, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 1'b0, 1'b1, 1'b0);

    // Inputs changed after acceptance are ignored.
    access(1, 1'b1, 32'h20, 32'h1111_1111, 32'h0, 1'b0, 1'b1, 1'b0);
    access(1, 1'b1, 32'h8, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b1, 1'b1);
    access(1, 1'b0, 32'h8, 32'h0, 32'hA5A5_A5A5, 1'b0, 1'b1, 1'b0);
    access(1, 1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0, 1'b1, 1'b0);

    // Address 0x400 wraps to word 0 unless range checking is built in.
    access(0, 1'b1, 32'h400, 32'h77, 32'h0, ErrEn, 1'b1, 1'b0);
    access(0, 1'b0, 32'h0, 32'h0, ErrEn ? 32'h1234_5678 : 32'h77, 1'b0, 1'b1, 1'b0);

    // Reset during the wait phase of a LATENCY=3 write.
    access(3, 1'b1, 32'h4, 32'h99, 32'h0, 1'b0, 1'b1, 1'b0);
    access(3, 1'b1, 32'h4, 32'h55, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mem_rdy after reset", 32'(rdy_m), 32'd1);
    repeat (6) @(negedge clk);
    access(3, 1'b0, 32'h4, 32'h0, 32'h99, 1'b0, 1'b1, 1'b0);

    // LATENCY=2: preload four words, then read them with proc_req held high.
    for (int i = 0; i < 4; i++) access(2, 1'b1, 32'(i * 4), vals[i], 32'h0, 1'b0, 1'b1, 1'b0);
    sel = 2;
    @(negedge clk);
    we = 1'b0;
    proc_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 32'(i * 4);
      n = 0;
      while (!rdy_m && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1;
      e.data = vals[i];
      e.err  = 1'b0;
      e.cyc  = cyc + 2;
      sbq.push_back(e);
      @(negedge clk);
    end
    proc_req = 1'b0;
    drain();

    // Reset asserted in the response cycle of a LATENCY=2 write: nothing commits.
    access(2, 1'b1, 32'h4, 32'hCD, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    access(2, 1'b0, 32'h4, 32'h0, 32'h2222_2222, 1'b0, 1'b1, 1'b0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
